// File: rtl/sync_period_meter_pkg.sv
// Shared scaling constants and FSM encoding for the sync period meter and the lut_n tables.
// Both sides import this package so their count scaling always agrees.
package sync_period_meter_pkg;

    localparam int N_SYNC  = 50;
    localparam int CNT_W   = 14;
    localparam int MIN_GAP = 8;
    localparam int MIN_CNT = 666;
    localparam int MAX_CNT = 5000;

    typedef enum logic {
        ACQUIRE = 1'b0,
        MEASURE = 1'b1
    } state_t;

    function automatic logic cnt_in_range(input logic [CNT_W-1:0] n);
        return (n >= CNT_W'(MIN_CNT)) && (n <= CNT_W'(MAX_CNT));
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises the external sync wave, finds rising edges and drops edges that
// follow the previous accepted edge by fewer than MIN_GAP clocks.
module sync_edge_detect
    import sync_period_meter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic edge_acc
);

    localparam int GAP_W = $clog2(MIN_GAP + 1);

    // [0] metastability stage, [1] synchronised level, [2] edge register
    logic [2:0]       sync_pipe_reg;
    logic [GAP_W-1:0] gap_reg;
    logic             edge_det;
    logic             gap_ok;

    assign edge_det = sync_pipe_reg[1] & ~sync_pipe_reg[2];
    assign gap_ok   = (gap_reg >= GAP_W'(MIN_GAP));
    assign edge_acc = edge_det & gap_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_pipe_reg <= '0;
            gap_reg       <= '0;
        end else begin
            sync_pipe_reg <= {sync_pipe_reg[1:0], sync_in};
            if (edge_acc) begin
                gap_reg <= '0;
            end else if (!gap_ok) begin
                gap_reg <= gap_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_period_meter.sv
// Counts clk periods spanning N_SYNC accepted sync rising edges; the closing edge
// of one window opens the next, so consecutive results have no dead time.
module sync_period_meter
    import sync_period_meter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_in,
    output logic [CNT_W-1:0] n_clk_cnts,
    output logic             cnt_valid,
    output logic             in_range,
    output logic             overflow
);

    localparam int               EDGE_W  = $clog2(N_SYNC + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic              edge_acc;
    state_t            state_reg;
    logic [CNT_W-1:0]  win_cnt_reg;
    logic [EDGE_W-1:0] edge_cnt_reg;
    logic              window_close;

    sync_edge_detect u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_in  (sync_in),
        .edge_acc (edge_acc)
    );

    assign window_close = edge_acc && (edge_cnt_reg == EDGE_W'(N_SYNC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ACQUIRE;
            win_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            n_clk_cnts   <= CNT_SAT;
            cnt_valid    <= 1'b0;
            in_range     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            cnt_valid <= 1'b0;
            case (state_reg)
                ACQUIRE: begin
                    if (edge_acc) begin
                        win_cnt_reg  <= CNT_W'(1);
                        edge_cnt_reg <= '0;
                        state_reg    <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A closing edge takes priority over saturation in the same cycle.
                    if (window_close) begin
                        n_clk_cnts   <= win_cnt_reg;
                        in_range     <= cnt_in_range(win_cnt_reg);
                        overflow     <= 1'b0;
                        cnt_valid    <= 1'b1;
                        win_cnt_reg  <= CNT_W'(1);
                        edge_cnt_reg <= '0;
                    end else if (win_cnt_reg == CNT_SAT) begin
                        n_clk_cnts   <= CNT_SAT;
                        in_range     <= 1'b0;
                        overflow     <= 1'b1;
                        cnt_valid    <= 1'b1;
                        win_cnt_reg  <= '0;
                        edge_cnt_reg <= '0;
                        state_reg    <= ACQUIRE;
                    end else begin
                        win_cnt_reg <= win_cnt_reg + 1'b1;
                        if (edge_acc) begin
                            edge_cnt_reg <= edge_cnt_reg + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_period_meter.sv
// Scenario bench for sync_period_meter: a square-wave generator drives sync_in and a
// scoreboard of expected results is checked whenever cnt_valid pulses.
module tb_sync_period_meter;

    typedef struct {
        logic [13:0] cnts;
        logic        ir;
        logic        ov;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        sync_in;
    logic [13:0] n_clk_cnts;
    logic        cnt_valid;
    logic        in_range;
    logic        overflow;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    // generator controls
    bit gen_on    = 0;
    bit glitch_on = 0;
    bit running   = 0;
    int period    = 100;
    int phase     = 0;
    int start_cyc = 0;

    sync_period_meter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_in    (sync_in),
        .n_clk_cnts (n_clk_cnts),
        .cnt_valid  (cnt_valid),
        .in_range   (in_range),
        .overflow   (overflow)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // square wave: rising edge at phase 0; optional 1-clk low glitch at phase 3
    initial begin
        sync_in = 0;
        forever begin
            @(negedge clk);
            if (gen_on) begin
                if (!running) begin
                    running   = 1;
                    phase     = 0;
                    start_cyc = cyc;
                end
                sync_in = (phase < period / 2) && !(glitch_on && phase == 3);
                phase   = (phase + 1 == period) ? 0 : phase + 1;
            end else begin
                running = 0;
                sync_in = 0;
            end
        end
    end

    function automatic exp_t mk_exp(input int n, input logic ov);
        exp_t e;
        e.cnts = 14'(n);
        e.ir   = !ov && (n >= 666) && (n <= 5000);
        e.ov   = ov;
        return e;
    endfunction

    task automatic start_gen(input int p, input bit glitch);
        @(posedge clk);
        period    = p;
        glitch_on = glitch;
        gen_on    = 1;
    endtask

    task automatic stop_gen();
        @(posedge clk);
        gen_on = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        repeat (4) @(negedge clk);
        rst_n = 1;
        sb.delete();
        repeat (20) @(negedge clk);
    endtask

    // waits (bounded) for the next cnt_valid pulse and captures the outputs
    task automatic wait_valid(input int budget, output bit got, output int at_cyc,
                              output logic [13:0] cnts, output logic ir, output logic ov);
        got = 0; at_cyc = 0; cnts = '0; ir = 0; ov = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cnt_valid === 1'b1) begin
                got = 1; at_cyc = cyc; cnts = n_clk_cnts; ir = in_range; ov = overflow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (n_clk_cnts !== 14'h3FFF || cnt_valid !== 1'b0 || in_range !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b want=3fff/0/0/0", n_clk_cnts, cnt_valid, in_range, overflow);
        end
        rst_n = 1;
        repeat (20) @(negedge clk);
        checks++;
        if (n_clk_cnts !== 14'h3FFF || cnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h/%b want=3fff/0", n_clk_cnts, cnt_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_40k();
        bit got; int at; logic [13:0] c; logic ir, ov; exp_t e;
        start_gen(100, 0);
        sb.push_back(mk_exp(5000, 0));
        wait_valid(5400, got, at, c, ir, ov);
        checks++;
        if (!got || sb.size() == 0) begin
            failures++;
            $display("FAIL 40k_valid got=timeout want=pulse");
        end else begin
            e = sb.pop_front();
            checks += 4;
            if (c !== e.cnts) begin failures++; $display("FAIL 40k_cnts got=%0d want=%0d", c, e.cnts); end
            if (ir !== e.ir) begin failures++; $display("FAIL 40k_in_range got=%b want=%b", ir, e.ir); end
            if (ov !== e.ov) begin failures++; $display("FAIL 40k_overflow got=%b want=%b", ov, e.ov); end
            if (at - start_cyc !== 5003) begin
                failures++; $display("FAIL 40k_latency got=%0d want=5003", at - start_cyc);
            end
            @(negedge clk);
            checks++;
            if (cnt_valid !== 1'b0) begin failures++; $display("FAIL 40k_pulse_width got=1 want=0"); end
        end
        $display("test_40k cnts=%0d in_range=%b overflow=%b", c, ir, ov);
        stop_gen();
        do_reset();
    endtask

    task automatic test_back_to_back();
        bit got; int at, prev; logic [13:0] c; logic ir, ov; exp_t e;
        start_gen(20, 0);
        prev = 0;
        for (int w = 0; w < 3; w++) begin
            sb.push_back(mk_exp(1000, 0));
            wait_valid(1200, got, at, c, ir, ov);
            checks++;
            if (!got || sb.size() == 0) begin
                failures++;
                $display("FAIL b2b_valid win=%0d got=timeout want=pulse", w);
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (c !== e.cnts) begin failures++; $display("FAIL b2b_cnts win=%0d got=%0d want=%0d", w, c, e.cnts); end
                if (ir !== e.ir) begin failures++; $display("FAIL b2b_in_range win=%0d got=%b want=%b", w, ir, e.ir); end
                if (w == 0) begin
                    if (at - start_cyc !== 1003) begin
                        failures++; $display("FAIL b2b_first_latency got=%0d want=1003", at - start_cyc);
                    end
                end else if (at - prev !== 1000) begin
                    failures++; $display("FAIL b2b_interval win=%0d got=%0d want=1000", w, at - prev);
                end
            end
            prev = at;
            $display("test_back_to_back win=%0d cnts=%0d at=%0d", w, c, at);
        end
        stop_gen();
        do_reset();
    endtask

    task automatic test_glitch();
        bit got; int at; logic [13:0] c; logic ir, ov; exp_t e;
        start_gen(100, 1);
        sb.push_back(mk_exp(5000, 0));
        wait_valid(5400, got, at, c, ir, ov);
        checks++;
        if (!got || sb.size() == 0) begin
            failures++;
            $display("FAIL glitch_valid got=timeout want=pulse");
        end else begin
            e = sb.pop_front();
            checks += 3;
            if (c !== e.cnts) begin failures++; $display("FAIL glitch_cnts got=%0d want=%0d", c, e.cnts); end
            if (ir !== e.ir) begin failures++; $display("FAIL glitch_in_range got=%b want=%b", ir, e.ir); end
            if (at - start_cyc !== 5003) begin
                failures++; $display("FAIL glitch_latency got=%0d want=5003", at - start_cyc);
            end
        end
        $display("test_glitch cnts=%0d", c);
        stop_gen();
        glitch_on = 0;
        do_reset();
    endtask

    task automatic test_out_of_range();
        bit got; int at; logic [13:0] c; logic ir, ov; exp_t e;
        start_gen(13, 0);
        sb.push_back(mk_exp(650, 0));
        wait_valid(900, got, at, c, ir, ov);
        checks++;
        if (!got || sb.size() == 0) begin
            failures++;
            $display("FAIL oor_valid got=timeout want=pulse");
        end else begin
            e = sb.pop_front();
            checks += 4;
            if (c !== e.cnts) begin failures++; $display("FAIL oor_cnts got=%0d want=%0d", c, e.cnts); end
            if (ir !== e.ir) begin failures++; $display("FAIL oor_in_range got=%b want=%b", ir, e.ir); end
            if (ov !== e.ov) begin failures++; $display("FAIL oor_overflow got=%b want=%b", ov, e.ov); end
            if (at - start_cyc !== 653) begin
                failures++; $display("FAIL oor_latency got=%0d want=653", at - start_cyc);
            end
        end
        $display("test_out_of_range cnts=%0d in_range=%b", c, ir);
        stop_gen();
        do_reset();
    endtask

    task automatic test_overflow();
        bit got; int at, extra; logic [13:0] c; logic ir, ov; exp_t e;
        start_gen(100, 0);
        sb.push_back(mk_exp(16383, 1));
        repeat (950) @(negedge clk);
        stop_gen();
        wait_valid(16000, got, at, c, ir, ov);
        checks++;
        if (!got || sb.size() == 0) begin
            failures++;
            $display("FAIL ovf_valid got=timeout want=pulse");
        end else begin
            e = sb.pop_front();
            checks += 4;
            if (c !== e.cnts) begin failures++; $display("FAIL ovf_cnts got=%h want=%h", c, e.cnts); end
            if (ir !== e.ir) begin failures++; $display("FAIL ovf_in_range got=%b want=%b", ir, e.ir); end
            if (ov !== e.ov) begin failures++; $display("FAIL ovf_overflow got=%b want=%b", ov, e.ov); end
            if (at - start_cyc !== 16386) begin
                failures++; $display("FAIL ovf_latency got=%0d want=16386", at - start_cyc);
            end
        end
        $display("test_overflow cnts=%h overflow=%b", c, ov);
        extra = 0;
        repeat (300) begin
            @(negedge clk);
            if (cnt_valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL ovf_single_pulse got=%0d extra want=0", extra); end
        start_gen(100, 0);
        sb.push_back(mk_exp(5000, 0));
        wait_valid(5400, got, at, c, ir, ov);
        checks++;
        if (!got || sb.size() == 0) begin
            failures++;
            $display("FAIL ovf_restart_valid got=timeout want=pulse");
        end else begin
            e = sb.pop_front();
            checks += 4;
            if (c !== e.cnts) begin failures++; $display("FAIL ovf_restart_cnts got=%0d want=%0d", c, e.cnts); end
            if (ir !== e.ir) begin failures++; $display("FAIL ovf_restart_in_range got=%b want=%b", ir, e.ir); end
            if (ov !== e.ov) begin failures++; $display("FAIL ovf_restart_overflow got=%b want=%b", ov, e.ov); end
            if (at - start_cyc !== 5003) begin
                failures++; $display("FAIL ovf_restart_latency got=%0d want=5003", at - start_cyc);
            end
        end
        $display("test_overflow restart cnts=%0d overflow=%b", c, ov);
        stop_gen();
        do_reset();
    endtask

    task automatic test_mid_reset();
        bit got, seen; int at, rel; logic [13:0] c; logic ir, ov; exp_t e;
        start_gen(100, 0);
        seen = 0;
        repeat (2500) begin
            @(negedge clk);
            if (cnt_valid === 1'b1) seen = 1;
        end
        rst_n = 0;
        #1;
        checks++;
        if (n_clk_cnts !== 14'h3FFF || cnt_valid !== 1'b0 || in_range !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h/%b/%b/%b want=3fff/0/0/0", n_clk_cnts, cnt_valid, in_range, overflow);
        end
        repeat (5) begin
            @(negedge clk);
            if (cnt_valid === 1'b1) seen = 1;
        end
        rst_n = 1;
        rel = cyc;
        sb.delete();
        sb.push_back(mk_exp(5000, 0));
        wait_valid(5400, got, at, c, ir, ov);
        checks++;
        if (seen) begin failures++; $display("FAIL midrst_no_valid got=1 want=0"); end
        checks++;
        if (!got || sb.size() == 0) begin
            failures++;
            $display("FAIL midrst_valid got=timeout want=pulse");
        end else begin
            e = sb.pop_front();
            checks += 2;
            if (c !== e.cnts) begin failures++; $display("FAIL midrst_cnts got=%0d want=%0d", c, e.cnts); end
            if (at - rel < 5003 || at - rel > 5110) begin
                failures++; $display("FAIL midrst_fresh_window got=%0d want=5003..5110", at - rel);
            end
        end
        $display("test_mid_reset cnts=%0d after=%0d", c, at - rel);
        stop_gen();
        do_reset();
    endtask

    initial begin
        rst_n = 0;
        test_reset();
        test_40k();
        test_back_to_back();
        test_glitch();
        test_out_of_range();
        test_overflow();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
